// File: rtl/bus_write_monitor.sv
// Store-capture monitor: FIFO of core stores with done-address detection.
// Define BUS_WRITE_MONITOR_TIMESTAMP_EN to tag each entry with a cycle stamp.
module bus_write_monitor #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int DONE_ADDR = 220,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        data_adr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W+DATA_W-1:0] out_data,
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
  output logic [15:0]              out_time,
`endif
  output logic [CNT_W-1:0]         count,
  output logic                     done,
  output logic [DATA_W-1:0]        done_data,
  output logic                     overflow
);

  localparam int PAY_W = ADDR_W + DATA_W;
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
  localparam int ENT_W = PAY_W + 16;
`else
  localparam int ENT_W = PAY_W;
`endif

  localparam logic [ADDR_W-1:0] DONE_A = ADDR_W'(DONE_ADDR);
  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

  typedef enum logic {
    CAPTURE,
    STOPPED
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               done_set;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               done_q;
  logic               ovf_q;
  logic [DATA_W-1:0]  done_data_q;

  logic               push_req;
  logic               pop;
  logic               full;
  logic               push;
  logic               drop;
  logic [ENT_W-1:0]   entry;
  logic [ENT_W-1:0]   head;

`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
  logic [15:0]        ts_q;

  // Free-running stamp; deliberately untouched by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 16'd1;
  end

  assign entry = {ts_q, data_adr, write_data};
`else
  assign entry = {data_adr, write_data};
`endif

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_C);
  assign push_req  = mem_write && (state_q == CAPTURE) && !clear;
  assign pop       = out_valid && out_ready && !clear;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    if (clear) begin
      state_d = CAPTURE;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (mem_write && data_adr == DONE_A) begin
            state_d  = STOPPED;
            done_set = 1'b1;
          end
        end
        STOPPED: state_d = STOPPED;
        default: state_d = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CAPTURE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_data_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
      if (done_set) begin
        done_q      <= 1'b1;
        done_data_q <= write_data;
      end
    end
  end

  // Storage needs no reset: a slot is only visible once written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[PAY_W-1:0] : '0;
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
  assign out_time  = out_valid ? head[ENT_W-1 -: 16] : '0;
`endif
  assign count     = count_q;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bus_write_monitor.sv
// Random + directed bench for bus_write_monitor.
// Reference model is a queue of stores plus sticky flags.
module tb_bus_write_monitor;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_write = 1'b0;
  logic [12:0] data_adr = '0;
  logic [15:0] write_data = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [28:0] out_data;
  logic [4:0]  count;
  logic        done;
  logic [15:0] done_data;
  logic        overflow;
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
  logic [15:0] out_time;
`endif

  bus_write_monitor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_write  (mem_write),
    .data_adr   (data_adr),
    .write_data (write_data),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
    .out_time   (out_time),
`endif
    .count      (count),
    .done       (done),
    .done_data  (done_data),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [47:0] mq[$];
  bit          m_done;
  bit          m_ovf;
  bit          m_stop;
  logic [15:0] m_dd;
  logic [15:0] m_ts;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    logic [28:0] ed;
    ed = (mq.size() != 0) ? mq[0][28:0] : 29'd0;
    check("valid", 64'(out_valid), 64'(mq.size() != 0));
    check("data", 64'(out_data), 64'(ed));
    check("count", 64'(count), 64'(mq.size()));
    check("done", 64'(done), 64'(m_done));
    check("done_data", 64'(done_data), 64'(m_dd));
    check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
    check("time", 64'(out_time),
          64'((mq.size() != 0) ? mq[0][47:32] : 16'd0));
`endif
  endtask

  task automatic model_edge(input bit mw, input logic [12:0] adr,
                            input logic [15:0] wd, input bit rdy,
                            input bit clr);
    bit pop;
    pop = (mq.size() != 0) && rdy;
    if (clr) begin
      mq.delete();
      m_done = 0;
      m_ovf  = 0;
      m_stop = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mw && !m_stop) begin
        if (mq.size() < DEPTH) mq.push_back({m_ts, 3'b000, adr, wd});
        else m_ovf = 1;
        if (adr == 13'd220) begin
          m_stop = 1;
          m_done = 1;
          m_dd   = wd;
        end
      end
    end
    m_ts = m_ts + 16'd1;
  endtask

  task automatic step(input bit mw, input logic [12:0] adr,
                      input logic [15:0] wd, input bit rdy, input bit clr);
    mem_write  = mw;
    data_adr   = adr;
    write_data = wd;
    out_ready  = rdy;
    clear      = clr;
    @(posedge clk);
    model_edge(mw, adr, wd, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_write = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    #1;
    mq.delete();
    m_done = 0;
    m_ovf  = 0;
    m_stop = 0;
    m_dd   = '0;
    m_ts   = '0;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] last;
    bit rdy_hi;

    do_reset();

    // Two stores draining back to back.
    step(1, 13'h010, 16'h1234, 1, 0);
    check("t1_first", 64'(out_data), 64'({13'h010, 16'h1234}));
    step(1, 13'h011, 16'hABCD, 1, 0);
    check("t1_second", 64'(out_data), 64'({13'h011, 16'hABCD}));
    step(0, 13'h0, 16'h0, 1, 0);
    check("t1_empty", 64'(out_valid), 64'd0);
    check("t1_cnt0", 64'(count), 64'd0);

    // Overflow on the 17th store.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 13'h020, 16'(i), 0, 0);
    check("t2_cnt16", 64'(count), 64'd16);
    check("t2_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("t2_order", 64'(out_data[15:0]), 64'(i));
      step(0, 13'h0, 16'h0, 1, 0);
    end
    check("t2_drained", 64'(count), 64'd0);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 13'h040, 16'(i), 0, 0);
    step(1, 13'h040, 16'h0099, 1, 0);
    check("t3_cnt16", 64'(count), 64'd16);
    check("t3_no_ovf", 64'(overflow), 64'd0);
    last = '0;
    for (int i = 0; i < 16; i++) begin
      last = out_data[15:0];
      step(0, 13'h0, 16'h0, 1, 0);
    end
    check("t3_last", 64'(last), 64'h0099);

    // Done-address store then ignored stores.
    do_reset();
    step(1, 13'd220, 16'h4060, 0, 0);
    check("t4_done", 64'(done), 64'd1);
    check("t4_dd", 64'(done_data), 64'h4060);
    check("t4_entry", 64'(out_data), 64'({13'd220, 16'h4060}));
    for (int i = 0; i < 3; i++) step(1, 13'h030, 16'(i + 5), 0, 0);
    check("t4_cnt", 64'(count), 64'd1);

    // Clear beats a simultaneous store.
    step(1, 13'h030, 16'h1111, 0, 1);
    check("t5_cnt", 64'(count), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_dd_held", 64'(done_data), 64'h4060);
    step(1, 13'h031, 16'h2222, 0, 0);
    check("t5_recap", 64'(out_data), 64'({13'h031, 16'h2222}));

    // Async reset mid-drain.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 13'h050, 16'(i), 0, 0);
    step(0, 13'h0, 16'h0, 1, 0);
    check("t6_cnt5", 64'(count), 64'd5);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_cnt", 64'(count), 64'd0);
    do_reset();

`ifdef BUS_WRITE_MONITOR_TIMESTAMP_EN
    for (int i = 0; i < 7; i++) step(0, 13'h0, 16'h0, 0, 0);
    step(1, 13'h060, 16'h7777, 0, 0);
    check("t7_time", 64'(out_time), 64'd7);
    do_reset();
`endif

    // Randomized traffic with phases biased toward filling or draining.
    rdy_hi = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          mw;
      bit          rdy;
      bit          clr;
      logic [12:0] adr;
      if (i % 97 == 0) rdy_hi = !rdy_hi;
      mw  = ($urandom_range(0, 3) != 0);
      adr = ($urandom_range(0, 63) == 0) ? 13'd220
                                         : 13'($urandom_range(0, 63));
      rdy = rdy_hi ? ($urandom_range(0, 3) != 0)
                   : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(mw, adr, 16'($urandom), rdy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
